z_result_stage: RTL and testbench

Z_RESULT_STAGE -- requirements
Module: z_result_stage

---
 rtl/z_result_stage.sv | 129 ++++++++++++
 tb/tb_z_result_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/z_result_stage.sv
// Result stage: buffers ALU results in a small FIFO and drains them onto a shared bus
// as LO (and optionally HI) beats. Define Z_FLAGS_EN to build the zero/negative flags.
module z_result_stage #(
  parameter int unsigned BITS  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              z_in,
  input  logic              hi_en,
  input  logic [2*BITS-1:0] result_in,
  output logic              z_ready,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic              bus_valid,
  output logic [BITS-1:0]   bus_out,
  output logic              bus_last,
  output logic              overflow,
  output logic              zero_flag,
  output logic              neg_flag
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StLo, StHi} state_e;

  state_e r_state, w_state_d;

  logic [2*BITS-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_hi;
  logic [PtrW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CntW-1:0]   r_count, w_count_d;
  logic              r_overflow;

  logic              w_full, w_push, w_pop;
  logic [2*BITS-1:0] w_head;
  logic              w_head_hi;

  assign w_full    = (r_count == CntW'(DEPTH));
  assign z_ready   = ~w_full;
  assign w_push    = z_in & ~w_full;
  assign w_head    = r_data[r_rd_ptr];
  assign w_head_hi = r_hi[r_rd_ptr];
  // Pop decode kept outside the FSM block so the next-state path has no comb loop.
  assign w_pop     = ((r_state == StLo) & ~w_head_hi) | (r_state == StHi);
  assign w_count_d = r_count + CntW'(w_push) - CntW'(w_pop);
  assign overflow  = r_overflow;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data[r_wr_ptr] <= result_in;
      r_hi[r_wr_ptr]   <= hi_en;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_state    <= StIdle;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count    <= w_count_d;
      r_overflow <= r_overflow | (z_in & w_full);
      r_state    <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    bus_req   = 1'b0;
    bus_valid = 1'b0;
    bus_last  = 1'b0;
    bus_out   = '0;
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) w_state_d = StReq;
      end
      StReq: begin
        bus_req = 1'b1;
        if (bus_grant) w_state_d = StLo;
      end
      StLo: begin
        bus_valid = 1'b1;
        bus_out   = w_head[BITS-1:0];
        bus_last  = ~w_head_hi;
        if (w_head_hi) w_state_d = StHi;
        else           w_state_d = (w_count_d != '0) ? StReq : StIdle;
      end
      StHi: begin
        bus_valid = 1'b1;
        bus_out   = w_head[2*BITS-1:BITS];
        bus_last  = 1'b1;
        w_state_d = (w_count_d != '0) ? StReq : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

`ifdef Z_FLAGS_EN
  logic r_zero, r_neg;
  logic w_zero_d, w_neg_d;

  assign w_zero_d = hi_en ? (result_in == '0) : (result_in[BITS-1:0] == '0);
  assign w_neg_d  = hi_en ? result_in[2*BITS-1] : result_in[BITS-1];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_zero <= 1'b0;
      r_neg  <= 1'b0;
    end else if (w_push) begin
      r_zero <= w_zero_d;
      r_neg  <= w_neg_d;
    end
  end

  assign zero_flag = r_zero;
  assign neg_flag  = r_neg;
`else
  assign zero_flag = 1'b0;
  assign neg_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_z_result_stage.sv
// Scoreboard bench for z_result_stage: stimulus pushes expected bus beats, a negedge
// monitor pops and compares every beat the DUT presents.
module tb_z_result_stage;
  localparam int BITS  = 32;
  localparam int DEPTH = 2;
`ifdef Z_FLAGS_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            clr, z_in, hi_en, bus_grant;
  logic [2*BITS-1:0] result_in;
  logic            z_ready, bus_req, bus_valid, bus_last, overflow, zero_flag, neg_flag;
  logic [BITS-1:0] bus_out;

  typedef struct packed {
    logic [BITS-1:0] data;
    logic            last;
  } beat_t;

  beat_t sb_q[$];
  beat_t mon_e;
  int    total = 0;
  int    bad   = 0;

  z_result_stage #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .z_in      (z_in),
    .hi_en     (hi_en),
    .result_in (result_in),
    .z_ready   (z_ready),
    .bus_req   (bus_req),
    .bus_grant (bus_grant),
    .bus_valid (bus_valid),
    .bus_out   (bus_out),
    .bus_last  (bus_last),
    .overflow  (overflow),
    .zero_flag (zero_flag),
    .neg_flag  (neg_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %0h last=%0b expected no beat", bus_out, bus_last);
      end else begin
        mon_e = sb_q.pop_front();
        check("beat_data", 64'(bus_out), 64'(mon_e.data));
        check("beat_last", 64'(bus_last), 64'(mon_e.last));
      end
    end
  end

  task automatic push_beat(input logic [BITS-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    sb_q.push_back(b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one z_in pulse; accept says whether the bench expects it to be buffered.
  task automatic capture(input logic hi, input logic [2*BITS-1:0] val, input bit accept);
    z_in      = 1'b1;
    hi_en     = hi;
    result_in = val;
    if (accept) begin
      push_beat(val[BITS-1:0], ~hi);
      if (hi) push_beat(val[2*BITS-1:BITS], 1'b1);
    end
    tick();
    z_in = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) tick();
    check(name, 64'(sb_q.size()), 64'd0);
    tick();
    tick();
    check({name, "_idle_valid"}, 64'(bus_valid), 64'd0);
    check({name, "_idle_req"}, 64'(bus_req), 64'd0);
  endtask

  task automatic check_flags(input string name, input logic z, input logic n);
    check({name, "_zero"}, 64'(zero_flag), 64'(FlagsEn ? z : 1'b0));
    check({name, "_neg"}, 64'(neg_flag), 64'(FlagsEn ? n : 1'b0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b0; z_in = 1'b0; hi_en = 1'b0; result_in = '0; bus_grant = 1'b0;
    #12;
    check("rst_req", 64'(bus_req), 64'd0);
    check("rst_valid", 64'(bus_valid), 64'd0);
    check("rst_last", 64'(bus_last), 64'd0);
    check("rst_out", 64'(bus_out), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_ready", 64'(z_ready), 64'd1);
    check_flags("rst", 1'b0, 1'b0);
    tick();
    clr = 1'b1;
    tick();

    // Single-word result and latency
    bus_grant = 1'b1;
    capture(1'b0, 64'h0000_0000_0000_0005, 1'b1);
    check("t1_idle_after_cap", 64'(bus_req), 64'd0);
    tick();
    check("t1_req", 64'(bus_req), 64'd1);
    check("t1_req_novalid", 64'(bus_valid), 64'd0);
    tick();
    check("t1_lo_valid", 64'(bus_valid), 64'd1);
    check("t1_lo_noreq", 64'(bus_req), 64'd0);
    tick();
    check("t1_idle_valid", 64'(bus_valid), 64'd0);
    check("t1_idle_req", 64'(bus_req), 64'd0);
    check_flags("t1", 1'b0, 1'b0);

    // Double-word results and flag patterns
    capture(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    drain("t2_drain");
    check_flags("t2", 1'b0, 1'b1);
    capture(1'b0, 64'hABCD_0000_0000_0000, 1'b1);
    drain("t2b_drain");
    check_flags("t2b", 1'b1, 1'b0);
    capture(1'b0, 64'h0000_0000_8000_0000, 1'b1);
    drain("t2c_drain");
    check_flags("t2c", 1'b0, 1'b1);
    capture(1'b1, 64'h0000_0001_0000_0000, 1'b1);
    drain("t2d_drain");
    check_flags("t2d", 1'b0, 1'b0);

    // Full and overflow
    bus_grant = 1'b0;
    capture(1'b0, 64'h11, 1'b1);
    check("t3_ready1", 64'(z_ready), 64'd1);
    capture(1'b0, 64'h22, 1'b1);
    check("t3_ready0", 64'(z_ready), 64'd0);
    check("t3_ovf0", 64'(overflow), 64'd0);
    capture(1'b0, 64'h0, 1'b0);
    check("t3_ovf1", 64'(overflow), 64'd1);
    check("t3_still_full", 64'(z_ready), 64'd0);
    check_flags("t3_hold", 1'b0, 1'b0);
    bus_grant = 1'b1;
    drain("t3_drain");
    check("t3_ovf_sticky", 64'(overflow), 64'd1);
    check("t3_ready_after", 64'(z_ready), 64'd1);

    // Grant withheld, then a single-cycle grant
    bus_grant = 1'b0;
    capture(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t4_req_held", 64'(bus_req), 64'd1);
      check("t4_no_valid", 64'(bus_valid), 64'd0);
      tick();
    end
    bus_grant = 1'b1;
    tick();
    bus_grant = 1'b0;
    drain("t4_drain");

    // Reset during the HI beat
    bus_grant = 1'b1;
    capture(1'b1, 64'hCAFE_BABE_DEAD_BEEF, 1'b0);
    push_beat(32'hDEAD_BEEF, 1'b0);
    tick();
    tick();
    tick();
    check("t5_in_hi", 64'(bus_valid), 64'd1);
    clr = 1'b0;
    #1;
    check("t5_rst_valid", 64'(bus_valid), 64'd0);
    check("t5_rst_out", 64'(bus_out), 64'd0);
    check("t5_rst_last", 64'(bus_last), 64'd0);
    check("t5_rst_req", 64'(bus_req), 64'd0);
    check("t5_rst_ovf", 64'(overflow), 64'd0);
    check("t5_rst_ready", 64'(z_ready), 64'd1);
    check_flags("t5_rst", 1'b0, 1'b0);
    #10;
    clr = 1'b1;
    tick();
    tick();
    tick();
    check("t5_post_req", 64'(bus_req), 64'd0);
    check("t5_post_valid", 64'(bus_valid), 64'd0);
    check("t5_sb_empty", 64'(sb_q.size()), 64'd0);

    // Push during the final beat of a draining entry
    bus_grant = 1'b1;
    capture(1'b0, 64'hAA, 1'b1);
    tick();
    tick();
    check("t6_lo", 64'(bus_valid), 64'd1);
    check("t6_ready", 64'(z_ready), 64'd1);
    capture(1'b0, 64'hBB, 1'b1);
    check("t6_back_to_req", 64'(bus_req), 64'd1);
    check("t6_req_novalid", 64'(bus_valid), 64'd0);
    check("t6_ready_after", 64'(z_ready), 64'd1);
    drain("t6_drain");

    check("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
